// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: IF/ID latch, 32x32 register file, hazard detection, ID/EX latch
// Optional ID_WB_BYPASS_EN: same-cycle write-back data is forwarded to register reads.
module id_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Inst,
    input  logic        WbWrite,
    input  logic [4:0]  WbReg,
    input  logic [31:0] WbData,
    output logic        Branch,
    output logic        Jump,
    output logic        Stall,
    output logic [31:0] BranchOffset,
    output logic [25:0] JumpAddress,
    output logic [31:0] ExRegA,
    output logic [31:0] ExRegB,
    output logic [31:0] ExImm,
    output logic [4:0]  ExDest,
    output logic [2:0]  ExAluOp,
    output logic        ExMemRead,
    output logic        ExMemWrite,
    output logic        ExRegWrite
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0] if_id_q, if_id_d;
    logic [31:0] rf_q [32];
    logic [31:0] ex_rega_q, ex_rega_d, ex_regb_q, ex_regb_d, ex_imm_q, ex_imm_d;
    logic [4:0]  ex_dest_q, ex_dest_d;
    logic [2:0]  ex_aluop_q, ex_aluop_d;
    logic        ex_memread_q, ex_memread_d, ex_memwrite_q, ex_memwrite_d;
    logic        ex_regwrite_q, ex_regwrite_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] reg_a, reg_b, imm_sx;
    logic        is_branch, uses_rt, load_use, br_hazard, ex_load;
    logic        dec_valid, dec_mr, dec_mw, dec_rw;
    logic [2:0]  dec_alu;
    logic [4:0]  dec_dest;

    assign op     = if_id_q[31:26];
    assign rs     = if_id_q[25:21];
    assign rt     = if_id_q[20:16];
    assign rd     = if_id_q[15:11];
    assign funct  = if_id_q[5:0];
    assign imm_sx = {{16{if_id_q[15]}}, if_id_q[15:0]};

    always_comb begin
        reg_a = (rs == 5'd0) ? 32'd0 : rf_q[rs];
        reg_b = (rt == 5'd0) ? 32'd0 : rf_q[rt];
`ifdef ID_WB_BYPASS_EN
        if (WbWrite && WbReg != 5'd0 && WbReg == rs) reg_a = WbData;
        if (WbWrite && WbReg != 5'd0 && WbReg == rt) reg_b = WbData;
`endif
    end

    // Branches resolve here, so they also need any in-flight ALU result, not just loads.
    assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign uses_rt   = (op == OP_RTYPE) || is_branch || (op == OP_SW);
    assign load_use  = ex_memread_q && (ex_dest_q != 5'd0) &&
                       ((ex_dest_q == rs) || (uses_rt && ex_dest_q == rt));
    assign br_hazard = is_branch && ex_regwrite_q && (ex_dest_q != 5'd0) &&
                       ((ex_dest_q == rs) || (ex_dest_q == rt));

    assign Stall        = load_use || br_hazard;
    assign Branch       = !Stall && (((op == OP_BEQ) && (reg_a == reg_b)) ||
                                     ((op == OP_BNE) && (reg_a != reg_b)));
    assign Jump         = !Stall && (op == OP_J);
    assign BranchOffset = imm_sx;
    assign JumpAddress  = if_id_q[25:0];

    always_comb begin
        dec_valid = 1'b0;
        dec_alu   = 3'd0;
        dec_dest  = 5'd0;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        dec_rw    = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_dest = rd;
                dec_rw   = 1'b1;
                case (funct)
                    6'h20:   begin dec_valid = 1'b1; dec_alu = 3'd0; end
                    6'h22:   begin dec_valid = 1'b1; dec_alu = 3'd1; end
                    6'h24:   begin dec_valid = 1'b1; dec_alu = 3'd2; end
                    6'h25:   begin dec_valid = 1'b1; dec_alu = 3'd3; end
                    6'h2A:   begin dec_valid = 1'b1; dec_alu = 3'd4; end
                    default: dec_valid = 1'b0;
                endcase
            end
            OP_ADDI: begin dec_valid = 1'b1; dec_dest = rt; dec_rw = 1'b1; end
            OP_LW:   begin dec_valid = 1'b1; dec_dest = rt; dec_rw = 1'b1; dec_mr = 1'b1; end
            OP_SW:   begin dec_valid = 1'b1; dec_mw = 1'b1; end
            default: dec_valid = 1'b0;
        endcase
    end

    // beq/bne/j and anything undecodable enter ID/EX as an all-zero bubble.
    always_comb begin
        if_id_d = if_id_q;
        if (!Stall) if_id_d = (Branch || Jump) ? 32'd0 : Inst;
        ex_load       = dec_valid && !Stall;
        ex_rega_d     = ex_load ? reg_a    : 32'd0;
        ex_regb_d     = ex_load ? reg_b    : 32'd0;
        ex_imm_d      = ex_load ? imm_sx   : 32'd0;
        ex_dest_d     = ex_load ? dec_dest : 5'd0;
        ex_aluop_d    = ex_load ? dec_alu  : 3'd0;
        ex_memread_d  = ex_load && dec_mr;
        ex_memwrite_d = ex_load && dec_mw;
        ex_regwrite_d = ex_load && dec_rw;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            if_id_q       <= 32'd0;
            ex_rega_q     <= 32'd0;
            ex_regb_q     <= 32'd0;
            ex_imm_q      <= 32'd0;
            ex_dest_q     <= 5'd0;
            ex_aluop_q    <= 3'd0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_regwrite_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            if_id_q       <= if_id_d;
            ex_rega_q     <= ex_rega_d;
            ex_regb_q     <= ex_regb_d;
            ex_imm_q      <= ex_imm_d;
            ex_dest_q     <= ex_dest_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
            ex_regwrite_q <= ex_regwrite_d;
            if (WbWrite && WbReg != 5'd0) rf_q[WbReg] <= WbData;
        end
    end

    assign ExRegA     = ex_rega_q;
    assign ExRegB     = ex_regb_q;
    assign ExImm      = ex_imm_q;
    assign ExDest     = ex_dest_q;
    assign ExAluOp    = ex_aluop_q;
    assign ExMemRead  = ex_memread_q;
    assign ExMemWrite = ex_memwrite_q;
    assign ExRegWrite = ex_regwrite_q;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized self-checking bench for id_stage against a behavioural pipeline model
module tb_id_stage;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] Inst = 32'd0;
    logic        WbWrite = 1'b0;
    logic [4:0]  WbReg = 5'd0;
    logic [31:0] WbData = 32'd0;
    logic        Branch, Jump, Stall;
    logic [31:0] BranchOffset;
    logic [25:0] JumpAddress;
    logic [31:0] ExRegA, ExRegB, ExImm;
    logic [4:0]  ExDest;
    logic [2:0]  ExAluOp;
    logic        ExMemRead, ExMemWrite, ExRegWrite;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: architectural register values and the two pipeline latches.
    logic [31:0] m_ifid;
    logic [31:0] m_rf [32];
    logic [31:0] m_a, m_b, m_imm;
    logic [4:0]  m_dst;
    logic [2:0]  m_alu;
    logic        m_mr, m_mw, m_rw;

    id_stage dut (
        .Clk(Clk), .Rst(Rst), .Inst(Inst), .WbWrite(WbWrite), .WbReg(WbReg), .WbData(WbData),
        .Branch(Branch), .Jump(Jump), .Stall(Stall), .BranchOffset(BranchOffset),
        .JumpAddress(JumpAddress), .ExRegA(ExRegA), .ExRegB(ExRegB), .ExImm(ExImm),
        .ExDest(ExDest), .ExAluOp(ExAluOp), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
        .ExRegWrite(ExRegWrite)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_ifid = 32'd0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_a = 32'd0; m_b = 32'd0; m_imm = 32'd0; m_dst = 5'd0; m_alu = 3'd0;
        m_mr = 1'b0; m_mw = 1'b0; m_rw = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] r, input logic ww,
                                               input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (ww && wr == r) return wd;
`endif
        return m_rf[r];
    endfunction

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input logic [31:0] inst, input logic ww, input logic [4:0] wr,
                        input logic [31:0] wd);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, dst;
        logic [31:0] a, b, sx;
        logic        st, tk, jp, ok, mr, mw, rw, br, rt_used;
        logic [2:0]  alu;
        @(negedge Clk);
        Inst = inst; WbWrite = ww; WbReg = wr; WbData = wd;
        #1;
        op = m_ifid[31:26]; rs = m_ifid[25:21]; rt = m_ifid[20:16];
        rd = m_ifid[15:11]; fn = m_ifid[5:0];
        a  = model_read(rs, ww, wr, wd);
        b  = model_read(rt, ww, wr, wd);
        sx = {{16{m_ifid[15]}}, m_ifid[15:0]};
        br = (op == 6'h04) || (op == 6'h05);
        rt_used = (op == 6'h00) || br || (op == 6'h2B);
        st = (m_mr && m_dst != 0 && (m_dst == rs || (rt_used && m_dst == rt))) ||
             (br && m_rw && m_dst != 0 && (m_dst == rs || m_dst == rt));
        tk = !st && ((op == 6'h04 && a == b) || (op == 6'h05 && a != b));
        jp = !st && (op == 6'h02);
        chk("stall", Stall, st);
        chk("branch", Branch, tk);
        chk("jump", Jump, jp);
        chk("boff", BranchOffset, sx);
        chk("jaddr", JumpAddress, m_ifid[25:0]);
        chk("ex_a", ExRegA, m_a);
        chk("ex_b", ExRegB, m_b);
        chk("ex_imm", ExImm, m_imm);
        chk("ex_dest", ExDest, m_dst);
        chk("ex_alu", ExAluOp, m_alu);
        chk("ex_mr", ExMemRead, m_mr);
        chk("ex_mw", ExMemWrite, m_mw);
        chk("ex_rw", ExRegWrite, m_rw);
        ok = 0; alu = 0; dst = 0; mr = 0; mw = 0; rw = 0;
        case (op)
            6'h00: begin
                dst = rd; rw = 1;
                case (fn)
                    6'h20: begin ok = 1; alu = 0; end
                    6'h22: begin ok = 1; alu = 1; end
                    6'h24: begin ok = 1; alu = 2; end
                    6'h25: begin ok = 1; alu = 3; end
                    6'h2A: begin ok = 1; alu = 4; end
                    default: ok = 0;
                endcase
            end
            6'h08: begin ok = 1; dst = rt; rw = 1; end
            6'h23: begin ok = 1; dst = rt; rw = 1; mr = 1; end
            6'h2B: begin ok = 1; mw = 1; end
            default: ok = 0;
        endcase
        @(posedge Clk);
        if (ww && wr != 0) m_rf[wr] = wd;
        if (st || !ok) begin
            m_a = 0; m_b = 0; m_imm = 0; m_dst = 0; m_alu = 0; m_mr = 0; m_mw = 0; m_rw = 0;
        end else begin
            m_a = a; m_b = b; m_imm = sx; m_dst = dst; m_alu = alu; m_mr = mr; m_mw = mw; m_rw = rw;
        end
        if (!st) m_ifid = (tk || jp) ? 32'd0 : inst;
    endtask

    task automatic reset_midcycle();
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        chk("rst_branch", Branch, 0);
        chk("rst_jump", Jump, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_boff", BranchOffset, 0);
        chk("rst_jaddr", JumpAddress, 0);
        chk("rst_ex_a", ExRegA, 0);
        chk("rst_ex_b", ExRegB, 0);
        chk("rst_ex_imm", ExImm, 0);
        chk("rst_ex_ctl", {ExDest, ExAluOp, ExMemRead, ExMemWrite, ExRegWrite}, 0);
        model_clear();
        Inst = 32'd0; WbWrite = 1'b1; WbReg = 5'd3; WbData = 32'hBAD0BAD0;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0; WbWrite = 1'b0;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [4:0]  s, t, d;
        logic [15:0] im;
        int          k;
        s  = 5'($urandom_range(0, 7));
        t  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        im = 16'($urandom);
        k  = $urandom_range(0, 11);
        case (k)
            0: return {6'h00, s, t, d, 5'd0, 6'h20};
            1: return {6'h00, s, t, d, 5'd0, 6'h22};
            2: return {6'h00, s, t, d, 5'd0, 6'h24};
            3: return {6'h00, s, t, d, 5'd0, 6'h25};
            4: return {6'h00, s, t, d, 5'd0, 6'h2A};
            5: return {6'h08, s, t, im};
            6: return {6'h23, s, t, im};
            7: return {6'h2B, s, t, im};
            8: return {6'h04, s, t, im};
            9: return {6'h05, s, t, im};
            10: return {6'h02, 26'($urandom)};
            default: return ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
        endcase
    endfunction

    initial begin
        model_clear();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("init_stall", Stall, 0);
        chk("init_ex_rw", ExRegWrite, 0);
        chk("init_ex_a", ExRegA, 0);
        Rst = 1'b0;

        // write r1=5, r2=7 then add r3,r1,r2
        step(32'd0, 1, 5'd1, 32'd5);
        step(32'd0, 1, 5'd2, 32'd7);
        step(32'h00221820, 0, 5'd0, 32'd0);
        step(32'd0, 0, 5'd0, 32'd0);
        #2;
        chk("add_a", ExRegA, 32'd5);
        chk("add_b", ExRegB, 32'd7);
        chk("add_alu", ExAluOp, 0);
        chk("add_dest", ExDest, 3);
        chk("add_rw", ExRegWrite, 1);

        // lw r4,0(r1) then add r5,r4,r4
        step(32'h8C240000, 0, 5'd0, 32'd0);
        step(32'h00842820, 0, 5'd0, 32'd0);
        #2 chk("lu_stall", Stall, 1);
        step(32'd0, 0, 5'd0, 32'd0);
        #2;
        chk("lu_stall_once", Stall, 0);
        chk("lu_bubble_mr", ExMemRead, 0);
        chk("lu_bubble_rw", ExRegWrite, 0);
        step(32'd0, 0, 5'd0, 32'd0);
        #2;
        chk("lu_add_dest", ExDest, 5);
        chk("lu_add_rw", ExRegWrite, 1);

        // beq r1,r2,+3 with r1=r2=9
        step(32'd0, 1, 5'd1, 32'd9);
        step(32'd0, 1, 5'd2, 32'd9);
        step(32'h10220003, 0, 5'd0, 32'd0);
        #2;
        chk("beq_taken", Branch, 1);
        chk("beq_off", BranchOffset, 32'h3);
        step(32'h00221820, 0, 5'd0, 32'd0);
        #2 chk("beq_squash", JumpAddress, 0);

        // j 0x40 then a squashed add
        step(32'h08000040, 0, 5'd0, 32'd0);
        #2;
        chk("j_jump", Jump, 1);
        chk("j_addr", JumpAddress, 26'h40);
        step(32'h00221820, 0, 5'd0, 32'd0);
        #2 chk("j_squash", JumpAddress, 0);

        // same-cycle write-back of r6 while add r7,r6,r0 is decoded
        step(32'd0, 1, 5'd6, 32'h11);
        step(32'h00C03820, 0, 5'd0, 32'd0);
        step(32'd0, 1, 5'd6, 32'hDEADBEEF);
`ifdef ID_WB_BYPASS_EN
        #2 chk("bypass_a", ExRegA, 32'hDEADBEEF);
`else
        #2 chk("bypass_a", ExRegA, 32'h11);
`endif

        reset_midcycle();
        step(32'd0, 0, 5'd0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_midcycle();
            step(rnd_inst(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports (name direction width meaning): Clk in 1 rising-edge clock; Rst in 1 reset, asynchronous, active-high.
REQ-002 SHALL have Inst in 32, instruction from fetch stage; WbWrite in 1, WbReg in 5, WbData in 32, write-back port.
REQ-003 SHALL have Branch out 1, Jump out 1, Stall out 1, BranchOffset out 32, JumpAddress out 26, all driven to the fetch stage.
REQ-004 SHALL have ExRegA out 32, ExRegB out 32, ExImm out 32, ExDest out 5, ExAluOp out 3, ExMemRead out 1, ExMemWrite out 1, ExRegWrite out 1, all from the ID/EX register.

Function
REQ-005 SHALL hold the IF/ID register IfId[31:0]; each rising Clk loads Inst unless Stall=1 (hold) or Branch|Jump=1 (load 0x00000000, squash).
REQ-006 SHALL contain a 32x32 register file; r0 reads 0; writes to r0 ignored; write on rising Clk when WbWrite=1.
REQ-007 SHALL decode IfId: R-type op 0x00 funct 0x20/0x22/0x24/0x25/0x2A -> ExAluOp 0/1/2/3/4 (add/sub/and/or/slt), dest rd; addi 0x08 -> add, dest rt; lw 0x23 -> add, MemRead, dest rt; sw 0x2B -> add, MemWrite, no RegWrite; beq 0x04; bne 0x05; j 0x02.
REQ-008 SHALL decode any other opcode/funct, and 0x00000000, as a bubble: ID/EX controls all 0.
REQ-009 SHALL sign-extend imm16 to ExImm and to BranchOffset (word offset, unshifted); JumpAddress = IfId[25:0].
REQ-010 SHALL assert Branch combinationally when IfId is beq with RegA==RegB, or bne with RegA!=RegB, and Stall=0.
REQ-011 SHALL assert Jump combinationally when IfId is j and Stall=0; Branch and Jump never both 1.
REQ-012 SHALL assert Stall (load-use) when ExMemRead=1, ExDest!=0, and ExDest equals rs, or rt for R-type/beq/bne/sw.
REQ-013 SHALL assert Stall (branch hazard) when IfId is beq/bne, ExRegWrite=1, ExDest!=0, and ExDest matches rs or rt.
REQ-014 SHALL load a bubble into ID/EX on a cycle with Stall=1; otherwise load decoded values; latency Inst -> Ex* = 2 rising edges.
REQ-015 SHALL give squash priority: Branch/Jump with Stall=0 loads ID/EX normally (branch/jump has no ID/EX effect beyond a bubble decode).
REQ-016 SHALL treat beq, bne, j as producing ExRegWrite=0, ExMemRead=0, ExMemWrite=0.

Reset
REQ-017 SHALL on Rst=1 immediately clear IfId to 0, all ID/EX outputs to 0, and all 32 registers to 0.
REQ-018 SHALL drive Branch=0, Jump=0, Stall=0, BranchOffset=0, JumpAddress=0 while Rst=1 (follows from IfId=0).
REQ-019 SHALL ignore WbWrite while Rst=1; Rst deassertion mid-stream resumes loading Inst on next rising Clk.

Configuration
REQ-020 SHALL, with ID_WB_BYPASS_EN defined, return WbData for a read of WbReg (nonzero) when WbWrite=1 in the same cycle.
REQ-021 SHALL, without ID_WB_BYPASS_EN, return the pre-write register value in that cycle; new value visible next cycle.

Verification
REQ-022 Reset: assert Rst mid-run -> all Ex* = 0, Branch/Jump/Stall = 0 without waiting for Clk.
REQ-023 WB then add: write r1=5, r2=7; Inst=add r3,r1,r2 (0x00221820) -> after 2 edges ExRegA=5, ExRegB=7, ExAluOp=0, ExDest=3, ExRegWrite=1.
REQ-024 Load-use: lw r4,0(r1) then add r5,r4,r4 -> Stall=1 for exactly one cycle, one bubble in ID/EX, IfId holds add.
REQ-025 Branch: r1=r2=9, beq r1,r2,+3 (0x10220003) in IfId -> Branch=1, BranchOffset=0x00000003, next IfId=0.
REQ-026 Jump: j 0x0000040 (0x08000040) -> Jump=1, JumpAddress=0x0000040, following instruction squashed.
REQ-027 Bypass: WbWrite=1 WbReg=6 WbData=0xDEADBEEF with IfId reading r6 -> ExRegA=0xDEADBEEF iff ID_WB_BYPASS_EN defined, else old value.
